fpu_issue_sched: RTL and testbench
==================================

// Module: fpu_issue_sched
// PURPOSE
//  Pipelined issue/writeback scheduler for the FPU: accepts one op per cycle over valid/ready,
//  routes operands to N_UNITS fully pipelined execution units, and tracks each in-flight op by latency.
//  Returns each result with its destination tag at a single writeback port.
//  Multiple ops may be in flight at once. Completion order follows latency, not issue order.
//  Sits between the core's FP decode stage and the FP register-file write port.
// PARAMETERS
//  W         32      operand/result width
//  N_UNITS   19      number of execution units; ctl selects unit index
//  CTL_W     5       width of ctl (>= clog2(N_UNITS))
//  TAG_W     5       destination-register tag width
//  MAX_LAT   7       largest unit latency supported; sets reservation depth
//  LAT_TABLE {..}    N_UNITS*4-bit packed vector; nibble i = latency L_i of unit i (0..MAX_LAT)
// PORTS
//  clk        in   1              clock
//  rstn       in   1              reset, synchronous, active-low
//  in_valid   in   1              op request
//  in_ready   out  1              op accepted at edge when in_valid&in_ready ("fire")
//  in_ctl     in   CTL_W          unit select
//  in_tag     in   TAG_W          destination tag
//  in_x1      in   W              operand 1; driven combinationally to unit_x1
//  in_x2      in   W              operand 2; driven combinationally to unit_x2
//  unit_x1    out  W              broadcast operand 1 to all units
//  unit_x2    out  W              broadcast operand 2 to all units
//  unit_y     in   N_UNITS*W      packed unit results
//  unit_ovf   in   N_UNITS        per-unit overflow; only used with FPU_EXC_FLAGS_EN
//  out_valid  out  1              result valid, one cycle pulse per op
//  out_tag    out  TAG_W          tag of the returned op
//  out_y      out  W              result
//  out_ovf    out  1              result overflow (FPU_EXC_FLAGS_EN only, else tied 0)
//  ovf_sticky out  1              sticky OR of out_ovf (FPU_EXC_FLAGS_EN only, else tied 0)
// BEHAVIOUR
//  Timing
//  - Op fired at edge E0 with latency L: unit_y[ctl] is valid in the cycle ending at edge E_L.
//    For L=0, that cycle is the fire cycle itself.
//  - The block captures the result at E_L. out_valid/out_tag/out_y are high in the cycle after E_L.
//  - Fire-to-out_valid latency is L+1 cycles.
//  Reservation table
//  - slot_v[0..MAX_LAT] with slot_sel and slot_tag per entry.
//  - slot_v[k]=1 means a capture is owed k edges from now.
//  - in_ready = ~slot_v[L(in_ctl)]. Ready depends on ctl, not on in_valid.
//  - At each edge: cap = slot_v[0] ? slot0 : (fire && L==0) ? new op : none.
//  - If cap exists: out_valid<=1, out_y<=unit_y[sel], out_tag<=tag. Otherwise out_valid<=0.
//  - Shift: slot[k] <= slot[k+1] for k<MAX_LAT; slot[MAX_LAT] <= 0.
//  - On fire with L>=1: slot[L-1] <= {1, ctl, tag}. The write overrides the shift; no collision is
//    possible because in_ready checked slot_v[L].
//  Boundaries
//  - At most one writeback per cycle by construction.
//  - A back-to-back mix of latencies may complete out of order; the tag disambiguates.
//  - in_ctl >= N_UNITS: treated as L=0 with result 0. Still returns its tag.
//  - LAT_TABLE entries > MAX_LAT: elaboration error via generate-time check.
//  Reset
//  - rstn=0 at any edge clears slot_v, out_valid, out_y, out_tag, out_ovf and ovf_sticky to 0.
//  - In-flight ops are dropped and never returned.
//  - in_ready reads 1 from the first cycle after reset.
// CONFIGURATION
//  FPU_EXC_FLAGS_EN
//  - Defined: out_ovf <= unit_ovf[sel] at the capture edge. ovf_sticky |= out_ovf.
//    Sticky clears only on reset.
//  - Undefined: unit_ovf is ignored; out_ovf=0 and ovf_sticky=0 constantly. No flag flops are built.
// STRUCTURE
//  - Shared package fpu_pkg holds: ctl encoding localparams (FADD=0 ... FSQR=18), default
//    LAT_TABLE constant, and a typedef for the slot entry struct {valid, sel, tag}.
//  - One sub-module: fpu_wb_resv. It holds the reservation shift table, is parametrised on
//    MAX_LAT/CTL_W/TAG_W, and exposes free_at[L] plus the slot-0 entry.
// TESTING
//  1 Single FADD (L=1), tag 3, x1=0x3F800000, x2=0x40000000 -> out_valid 2 cycles after fire,
//    out_tag=3, out_y=0x40400000.
//  2 FDIV(L=6) tag 1, then FADD(L=1) tag 2 next cycle -> tag 2 returns before tag 1.
//    Each returns exactly once.
//  3 Issue FMUL(L=2) at E0, then FADD(L=1) at E1 (same capture edge) -> in_ready=0 at E1.
//    FADD is accepted at E2.
//  4 FABS (L=0) every cycle for 10 cycles -> in_ready stays 1; 10 consecutive out_valid pulses
//    with matching tags.
//  5 rstn=0 while 3 ops are in flight -> no out_valid for any of them; in_ready=1 next cycle.
//  6 With FPU_EXC_FLAGS_EN: unit_ovf[FMUL]=1 on one op -> out_ovf=1 for that result only;
//    ovf_sticky holds 1 until reset.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: unit select encodings, default per-unit latency table and slot entry type.
package fpu_pkg;

  localparam int FPU_W       = 32;
  localparam int FPU_N_UNITS = 19;
  localparam int FPU_CTL_W   = 5;
  localparam int FPU_TAG_W   = 5;
  localparam int FPU_MAX_LAT = 7;

  localparam logic [4:0] FADD   = 5'd0;
  localparam logic [4:0] FSUB   = 5'd1;
  localparam logic [4:0] FMUL   = 5'd2;
  localparam logic [4:0] FDIV   = 5'd3;
  localparam logic [4:0] FMADD  = 5'd4;
  localparam logic [4:0] FMSUB  = 5'd5;
  localparam logic [4:0] FNMADD = 5'd6;
  localparam logic [4:0] FNMSUB = 5'd7;
  localparam logic [4:0] FMIN   = 5'd8;
  localparam logic [4:0] FMAX   = 5'd9;
  localparam logic [4:0] FABS   = 5'd10;
  localparam logic [4:0] FNEG   = 5'd11;
  localparam logic [4:0] FSGNJ  = 5'd12;
  localparam logic [4:0] FCMP   = 5'd13;
  localparam logic [4:0] FCVTWS = 5'd14;
  localparam logic [4:0] FCVTSW = 5'd15;
  localparam logic [4:0] FCLASS = 5'd16;
  localparam logic [4:0] FMV    = 5'd17;
  localparam logic [4:0] FSQR   = 5'd18;

  // Nibble i holds the latency of unit i; listed from FSQR (top) down to FADD (bottom).
  localparam logic [FPU_N_UNITS*4-1:0] FPU_LAT_TABLE = {
    4'd7,  // FSQR
    4'd0,  // FMV
    4'd0,  // FCLASS
    4'd2,  // FCVTSW
    4'd2,  // FCVTWS
    4'd1,  // FCMP
    4'd0,  // FSGNJ
    4'd0,  // FNEG
    4'd0,  // FABS
    4'd0,  // FMAX
    4'd0,  // FMIN
    4'd3,  // FNMSUB
    4'd3,  // FNMADD
    4'd3,  // FMSUB
    4'd3,  // FMADD
    4'd6,  // FDIV
    4'd2,  // FMUL
    4'd1,  // FSUB
    4'd1   // FADD
  };

  typedef struct packed {
    logic                 valid;
    logic [FPU_CTL_W-1:0] sel;
    logic [FPU_TAG_W-1:0] tag;
  } slot_t;

endpackage

// File: rtl/fpu_wb_resv.sv
// Writeback reservation table: slot k valid means a result capture is owed k edges from now.
// Shifts toward slot 0 every edge; a new booking at latency L lands in slot L-1 and overrides the shift.
module fpu_wb_resv
  import fpu_pkg::*;
#(
  parameter int MAX_LAT = FPU_MAX_LAT,
  parameter int CTL_W   = FPU_CTL_W,
  parameter int TAG_W   = FPU_TAG_W,
  parameter int LAT_W   = $clog2(MAX_LAT + 1)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               wr_en,
  input  logic [LAT_W-1:0]   wr_lat,
  input  logic [CTL_W-1:0]   wr_sel,
  input  logic [TAG_W-1:0]   wr_tag,
  output logic [MAX_LAT:0]   free_at,
  output logic               slot0_v,
  output logic [CTL_W-1:0]   slot0_sel,
  output logic [TAG_W-1:0]   slot0_tag
);

  logic [MAX_LAT:0] slot_v;
  logic [CTL_W-1:0] slot_sel [MAX_LAT];
  logic [TAG_W-1:0] slot_tag [MAX_LAT];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      slot_v <= '0;
    end else begin
      slot_v <= {1'b0, slot_v[MAX_LAT:1]};
      for (int k = 0; k < MAX_LAT; k++) begin
        if (wr_en && wr_lat == LAT_W'(k + 1)) slot_v[k] <= 1'b1;
      end
    end
  end

  // Payload needs no reset: it is only observed through slot_v.
  always_ff @(posedge clk) begin
    for (int k = 0; k < MAX_LAT - 1; k++) begin
      slot_sel[k] <= slot_sel[k+1];
      slot_tag[k] <= slot_tag[k+1];
    end
    for (int k = 0; k < MAX_LAT; k++) begin
      if (wr_en && wr_lat == LAT_W'(k + 1)) begin
        slot_sel[k] <= wr_sel;
        slot_tag[k] <= wr_tag;
      end
    end
  end

  assign free_at   = ~slot_v;
  assign slot0_v   = slot_v[0];
  assign slot0_sel = slot_sel[0];
  assign slot0_tag = slot_tag[0];

endmodule

// File: rtl/fpu_issue_sched.sv
// FPU issue/writeback scheduler: one op per cycle in, one tagged result per cycle out, L+1 cycle latency.
// Optional overflow flag return and sticky flag under FPU_EXC_FLAGS_EN.
module fpu_issue_sched
  import fpu_pkg::*;
#(
  parameter int                     W         = FPU_W,
  parameter int                     N_UNITS   = FPU_N_UNITS,
  parameter int                     CTL_W     = FPU_CTL_W,
  parameter int                     TAG_W     = FPU_TAG_W,
  parameter int                     MAX_LAT   = FPU_MAX_LAT,
  parameter logic [N_UNITS*4-1:0]   LAT_TABLE = FPU_LAT_TABLE
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CTL_W-1:0]     in_ctl,
  input  logic [TAG_W-1:0]     in_tag,
  input  logic [W-1:0]         in_x1,
  input  logic [W-1:0]         in_x2,
  output logic [W-1:0]         unit_x1,
  output logic [W-1:0]         unit_x2,
  input  logic [N_UNITS*W-1:0] unit_y,
  input  logic [N_UNITS-1:0]   unit_ovf,
  output logic                 out_valid,
  output logic [TAG_W-1:0]     out_tag,
  output logic [W-1:0]         out_y,
  output logic                 out_ovf,
  output logic                 ovf_sticky
);

  localparam int LAT_W = $clog2(MAX_LAT + 1);

  if (MAX_LAT < 1) begin : g_bad_max_lat
    $error("fpu_issue_sched: MAX_LAT must be at least 1");
  end

  logic [LAT_W-1:0] lat_tbl [N_UNITS];

  for (genvar i = 0; i < N_UNITS; i++) begin : g_lat
    if (int'(LAT_TABLE[i*4 +: 4]) > MAX_LAT) begin : g_bad_lat
      $error("fpu_issue_sched: LAT_TABLE entry %0d exceeds MAX_LAT", i);
    end
    assign lat_tbl[i] = LAT_W'(LAT_TABLE[i*4 +: 4]);
  end

  logic [LAT_W-1:0] cur_lat;
  logic             fire;
  logic [MAX_LAT:0] free_at;
  logic             slot0_v;
  logic [CTL_W-1:0] slot0_sel;
  logic [TAG_W-1:0] slot0_tag;
  logic             cap_v;
  logic [CTL_W-1:0] cap_sel;
  logic [TAG_W-1:0] cap_tag;
  logic [W-1:0]     cap_y;

  // Unknown unit selects fall through with latency 0 and a zero result.
  always_comb begin
    cur_lat = '0;
    for (int i = 0; i < N_UNITS; i++) begin
      if (in_ctl == CTL_W'(i)) cur_lat = lat_tbl[i];
    end
  end

  assign in_ready = free_at[cur_lat];
  assign fire     = in_valid & in_ready;
  assign unit_x1  = in_x1;
  assign unit_x2  = in_x2;

  fpu_wb_resv #(
    .MAX_LAT (MAX_LAT),
    .CTL_W   (CTL_W),
    .TAG_W   (TAG_W),
    .LAT_W   (LAT_W)
  ) u_resv (
    .clk       (clk),
    .rstn      (rstn),
    .wr_en     (fire && (cur_lat != '0)),
    .wr_lat    (cur_lat),
    .wr_sel    (in_ctl),
    .wr_tag    (in_tag),
    .free_at   (free_at),
    .slot0_v   (slot0_v),
    .slot0_sel (slot0_sel),
    .slot0_tag (slot0_tag)
  );

  // A booked slot 0 and a latency-0 fire can never coincide: in_ready gated the latter.
  always_comb begin
    cap_v   = 1'b0;
    cap_sel = '0;
    cap_tag = '0;
    if (slot0_v) begin
      cap_v   = 1'b1;
      cap_sel = slot0_sel;
      cap_tag = slot0_tag;
    end else if (fire && (cur_lat == '0)) begin
      cap_v   = 1'b1;
      cap_sel = in_ctl;
      cap_tag = in_tag;
    end
  end

  always_comb begin
    cap_y = '0;
    for (int i = 0; i < N_UNITS; i++) begin
      if (cap_sel == CTL_W'(i)) cap_y = unit_y[i*W +: W];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      out_y     <= '0;
      out_tag   <= '0;
    end else begin
      out_valid <= cap_v;
      if (cap_v) begin
        out_y   <= cap_y;
        out_tag <= cap_tag;
      end
    end
  end

`ifdef FPU_EXC_FLAGS_EN
  logic cap_ovf;

  always_comb begin
    cap_ovf = 1'b0;
    for (int i = 0; i < N_UNITS; i++) begin
      if (cap_v && cap_sel == CTL_W'(i)) cap_ovf = unit_ovf[i];
    end
  end

  // Sticky follows the registered flag, so it rises one cycle after out_ovf.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      out_ovf    <= 1'b0;
      ovf_sticky <= 1'b0;
    end else begin
      out_ovf    <= cap_ovf;
      ovf_sticky <= ovf_sticky | out_ovf;
    end
  end
`else
  logic unused_ovf;
  assign unused_ovf = ^unit_ovf;
  assign out_ovf    = 1'b0;
  assign ovf_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_fpu_issue_sched.sv
// Scoreboard bench for fpu_issue_sched: directed ops, behavioural pipelined units, cycle-stamped expectations.
`timescale 1ns/1ps
module tb_fpu_issue_sched;
  import fpu_pkg::*;

  localparam int W  = 32;
  localparam int NU = 19;
  localparam int LAT_B [NU] = '{1, 1, 2, 6, 3, 3, 3, 3, 0, 0, 0, 0, 0, 1, 2, 2, 0, 0, 7};

  logic          clk = 1'b0;
  logic          rstn;
  logic          in_valid;
  logic          in_ready;
  logic [4:0]    in_ctl;
  logic [4:0]    in_tag;
  logic [W-1:0]  in_x1, in_x2;
  logic [W-1:0]  unit_x1, unit_x2;
  logic [NU*W-1:0] unit_y;
  logic [NU-1:0] unit_ovf;
  logic          out_valid;
  logic [4:0]    out_tag;
  logic [W-1:0]  out_y;
  logic          out_ovf;
  logic          ovf_sticky;
  logic          ovf_req;

  fpu_issue_sched dut (
    .clk        (clk),
    .rstn       (rstn),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_ctl     (in_ctl),
    .in_tag     (in_tag),
    .in_x1      (in_x1),
    .in_x2      (in_x2),
    .unit_x1    (unit_x1),
    .unit_x2    (unit_x2),
    .unit_y     (unit_y),
    .unit_ovf   (unit_ovf),
    .out_valid  (out_valid),
    .out_tag    (out_tag),
    .out_y      (out_y),
    .out_ovf    (out_ovf),
    .ovf_sticky (ovf_sticky)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- behavioural execution units ----------------
  function automatic real s2r(input logic [31:0] b);
    logic [63:0] d;
    if (b[30:0] == 31'd0) return 0.0;
    d = {b[31], 11'(b[30:23]) - 11'd127 + 11'd1023, b[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2s(input real r);
    logic [63:0] d;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return 32'd0;
    return {d[63], 8'(d[62:52] - 11'd1023 + 11'd127), d[51:29]};
  endfunction

  function automatic logic [31:0] fmodel(input int u, input logic [31:0] a, input logic [31:0] b);
    case (u)
      0:  return r2s(s2r(a) + s2r(b));
      1:  return r2s(s2r(a) - s2r(b));
      2:  return r2s(s2r(a) * s2r(b));
      3:  return r2s(s2r(a) / s2r(b));
      10: return {1'b0, a[30:0]};
      default: return a ^ b;
    endcase
  endfunction

  logic [31:0] h1 [8];
  logic [31:0] h2 [8];
  logic        hov [8];

  always @(posedge clk) begin
    for (int k = 7; k > 0; k--) begin
      h1[k]  <= h1[k-1];
      h2[k]  <= h2[k-1];
      hov[k] <= hov[k-1];
    end
    h1[0]  <= unit_x1;
    h2[0]  <= unit_x2;
    hov[0] <= ovf_req;
  end

  always_comb begin
    unit_y   = '0;
    unit_ovf = '0;
    for (int i = 0; i < NU; i++) begin
      if (LAT_B[i] == 0) begin
        unit_y[i*W +: W] = fmodel(i, unit_x1, unit_x2);
        unit_ovf[i]      = ovf_req;
      end else begin
        unit_y[i*W +: W] = fmodel(i, h1[LAT_B[i]-1], h2[LAT_B[i]-1]);
        unit_ovf[i]      = hov[LAT_B[i]-1];
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [4:0]  tag;
    logic [31:0] y;
    logic        ovf;
    int          at;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int n_out  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    int idx;
    if (out_valid) begin
      n_out++;
      idx = -1;
      foreach (sb[k]) if (idx < 0 && sb[k].at == cyc) idx = k;
      if (idx < 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: tag %0d y 0x%08h at cycle %0d, expected no result", out_tag, out_y, cyc);
      end else begin
        chk("out_tag", 32'(out_tag), 32'(sb[idx].tag));
        chk("out_y", out_y, sb[idx].y);
        chk("out_ovf", 32'(out_ovf), 32'(sb[idx].ovf));
        sb.delete(idx);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [4:0] ctl, input logic [4:0] tag, input logic [31:0] x1,
                      input logic [31:0] x2, input logic ovf, input bit push,
                      input logic [31:0] exp_y, input int exp_wait);
    int   waited;
    int   lat;
    exp_t e;
    waited   = 0;
    in_valid = 1'b1;
    in_ctl   = ctl;
    in_tag   = tag;
    in_x1    = x1;
    in_x2    = x2;
    ovf_req  = ovf;
    #1;
    while (!in_ready && waited < 20) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (exp_wait >= 0) chk("ready_wait", 32'(waited), 32'(exp_wait));
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: tag %0d never accepted, expected acceptance within 20 cycles", tag);
      in_valid = 1'b0;
      ovf_req  = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    lat = (int'(ctl) < NU) ? LAT_B[ctl] : 0;
    if (push) begin
      e.tag = tag;
      e.y   = exp_y;
`ifdef FPU_EXC_FLAGS_EN
      e.ovf = ovf && (int'(ctl) < NU);
`else
      e.ovf = 1'b0;
`endif
      e.at  = cyc + lat;
      sb.push_back(e);
    end
    in_valid = 1'b0;
    ovf_req  = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    chk(name, 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  initial begin
    int n0;
    rstn     = 1'b0;
    in_valid = 1'b0;
    in_ctl   = FADD;
    in_tag   = '0;
    in_x1    = '0;
    in_x2    = '0;
    ovf_req  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;

    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_tag", 32'(out_tag), 32'd0);
    chk("rst_out_y", out_y, 32'd0);
    chk("rst_out_ovf", 32'(out_ovf), 32'd0);
    chk("rst_sticky", 32'(ovf_sticky), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // single FADD: 1.0 + 2.0 = 3.0
    send(FADD, 5'd3, 32'h3F800000, 32'h40000000, 1'b0, 1'b1, 32'h40400000, 0);
    drain("drain_fadd");

    // long FDIV overtaken by a short FADD issued next cycle
    send(FDIV, 5'd1, 32'h40C00000, 32'h40000000, 1'b0, 1'b1, 32'h40400000, 0);
    send(FADD, 5'd2, 32'h3F800000, 32'h3F800000, 1'b0, 1'b1, 32'h40000000, 0);
    drain("drain_ooo");

    // FMUL then FADD aiming at the same capture edge: FADD stalls one cycle
    send(FMUL, 5'd4, 32'h40400000, 32'h40000000, 1'b0, 1'b1, 32'h40C00000, 0);
    send(FADD, 5'd11, 32'h40000000, 32'h40000000, 1'b0, 1'b1, 32'h40800000, 1);
    drain("drain_collide");

    // streaming latency-0 ops
    for (int i = 0; i < 10; i++)
      send(FABS, 5'(i), 32'hBF800000 + 32'(i), 32'h0, 1'b0, 1'b1, 32'h3F800000 + 32'(i), 0);
    drain("drain_fabs");

    // out-of-range unit select returns its tag with a zero result
    send(5'd25, 5'd10, 32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b1, 32'h0, 0);
    drain("drain_badctl");

    // reset with three ops in flight
    send(FDIV, 5'd5, 32'h40C00000, 32'h40000000, 1'b0, 1'b0, 32'h0, 0);
    send(FSQR, 5'd6, 32'h40800000, 32'h0, 1'b0, 1'b0, 32'h0, 0);
    send(FMUL, 5'd7, 32'h40000000, 32'h40000000, 1'b0, 1'b0, 32'h0, 0);
    n0   = n_out;
    rstn = 1'b0;
    @(posedge clk);
    #1;
    rstn   = 1'b1;
    in_ctl = FMUL;
    #1;
    chk("post_rst_ready", 32'(in_ready), 32'd1);
    repeat (12) @(posedge clk);
    #1;
    chk("dropped_after_reset", 32'(n_out), 32'(n0));

    // overflow flag on one FMUL only
    send(FMUL, 5'd8, 32'h3FC00000, 32'h40000000, 1'b1, 1'b1, 32'h40400000, 0);
    send(FMUL, 5'd9, 32'h40000000, 32'h40000000, 1'b0, 1'b1, 32'h40800000, 0);
    drain("drain_ovf");
    repeat (5) @(posedge clk);
    #1;
`ifdef FPU_EXC_FLAGS_EN
    chk("sticky_held", 32'(ovf_sticky), 32'd1);
`else
    chk("sticky_held", 32'(ovf_sticky), 32'd0);
`endif
    rstn = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    chk("sticky_cleared", 32'(ovf_sticky), 32'd0);
    chk("out_valid_cleared", 32'(out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog");
  end

endmodule
